// File: rtl/gpio_packet_receiver.sv
// gpio_packet_receiver: deserializes one framed packet (start, payload MSB first, stop) from gpio_packet.
// Define PARITY_CHECK_EN to expect an even-parity bit between the last payload bit and the stop bit.
module gpio_packet_receiver #(
  parameter int PACKET_WIDTH = 86,
  parameter int CNT_WIDTH    = 7
) (
  input  logic                    gpio_clock,
  input  logic                    reset_n,
  input  logic                    rx_enable,
  input  logic                    gpio_packet,
  input  logic                    packet_ready,
  input  logic                    clear_errors,
  output logic [PACKET_WIDTH-1:0] packet_data,
  output logic                    packet_valid,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a start bit (only while rx_enable=1)
  // DATA   | shifting in payload bits, MSB first; bit_cnt counts down to 0
  // PARITY | sampling the even-parity bit (PARITY_CHECK_EN builds only)
  // STOP   | sampling the stop bit and qualifying the frame
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PACKET_WIDTH-1:0] shift_q, shift_d;
  logic [PACKET_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q, overrun_d;
  logic                    busy_q, busy_d;
  logic                    parity_err_q, parity_err_d;
  logic                    frame_good;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
    parity_err_d = parity_err_q;
    frame_good   = 1'b0;

    if (valid_q && packet_ready) valid_d = 1'b0;
    if (clear_errors) overrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_enable && gpio_packet) begin
          state_d      = S_DATA;
          bit_cnt_d    = CNT_WIDTH'(PACKET_WIDTH - 1);
          parity_err_d = 1'b0;
        end
      end
      S_DATA: begin
        shift_d   = {shift_q[PACKET_WIDTH-2:0], gpio_packet};
        bit_cnt_d = bit_cnt_q - CNT_WIDTH'(1);
        if (bit_cnt_q == '0) begin
`ifdef PARITY_CHECK_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        parity_err_d = ^{shift_q, gpio_packet};
        state_d      = S_STOP;
      end
`endif
      S_STOP: begin
        state_d = S_IDLE;
        if (!gpio_packet && !parity_err_q) frame_good  = 1'b1;
        else                               frame_err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A good frame may reload the output on the same edge the consumer takes the old one.
    if (frame_good) begin
      if (!valid_q || packet_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge gpio_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign packet_data  = data_q;
  assign packet_valid = valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_gpio_packet_receiver.sv
// Bench for gpio_packet_receiver: frames driven bit by bit, accepted payloads checked against a queue.
module tb_gpio_packet_receiver;

  localparam int PW = 86;

  logic          gpio_clock = 1'b0;
  logic          reset_n;
  logic          rx_enable;
  logic          gpio_packet;
  logic          packet_ready;
  logic          clear_errors;
  logic [PW-1:0] packet_data;
  logic          packet_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [PW-1:0] sb_q[$];

  localparam logic [PW-1:0] P_SINGLE = {3'd5, 83'h1_2345_6789_ABCD_EF01_2345};
  localparam logic [PW-1:0] P_RST    = 86'h2A_5555_5555_5555_5555_5555;
  localparam logic [PW-1:0] P_GOOD2  = 86'h3F_0F0F_1234_8000_0001_FFFF;
  localparam logic [PW-1:0] P_A      = 86'h11_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [PW-1:0] P_B      = 86'h22_1111_2222_3333_4444_5555;
  localparam logic [PW-1:0] P_C      = 86'h0C_CCCC_0000_CCCC_0000_CCCC;
  localparam logic [PW-1:0] P_D      = 86'h3D_DDDD_1357_9BDF_2468_ACE0;
  localparam logic [PW-1:0] P_E      = 86'h01_8421_8421_8421_8421_8421;

  gpio_packet_receiver dut (
    .gpio_clock   (gpio_clock),
    .reset_n      (reset_n),
    .rx_enable    (rx_enable),
    .gpio_packet  (gpio_packet),
    .packet_ready (packet_ready),
    .clear_errors (clear_errors),
    .packet_data  (packet_data),
    .packet_valid (packet_valid),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 gpio_clock = ~gpio_clock;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable at the falling edge, so valid&ready here means acceptance on the next edge.
  always @(negedge gpio_clock) begin
    if (reset_n && packet_valid && packet_ready) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_pkt", packet_data, '1);
      end else begin
        check_val("sb_data", packet_data, sb_q.pop_front());
      end
    end
  end

  task automatic drive_bit(input logic b);
    gpio_packet = b;
    @(posedge gpio_clock);
    #1;
  endtask

  task automatic send_frame(input logic [PW-1:0] p, input logic stop_b, input logic par_flip,
                            input logic ready_at_stop, input logic push, input logic en_off,
                            input logic chk_lat);
    if (push) sb_q.push_back(p);
    drive_bit(1'b1);
    check_val("busy_after_start", busy, 1'b1);
    if (en_off) rx_enable = 1'b0;
    for (int i = PW - 1; i >= 0; i--) drive_bit(p[i]);
`ifdef PARITY_CHECK_EN
    drive_bit((^p) ^ par_flip);
`endif
    if (chk_lat) check_val("lat_early", packet_valid, 1'b0);
    if (ready_at_stop) packet_ready = 1'b1;
    drive_bit(stop_b);
    gpio_packet = 1'b0;
    if (en_off) rx_enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    rx_enable    = 1'b1;
    gpio_packet  = 1'b0;
    packet_ready = 1'b1;
    clear_errors = 1'b0;
    repeat (3) @(posedge gpio_clock);
    #1;
    check_val("rst_valid", packet_valid, 1'b0);
    check_val("rst_ferr", frame_err, 1'b0);
    check_val("rst_ovr", overrun, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_data", packet_data, '0);
    reset_n = 1'b1;
    drive_bit(1'b0);

    // single frame, exact latency, one-cycle valid
    send_frame(P_SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("single_valid", packet_valid, 1'b1);
    check_val("single_data", packet_data, P_SINGLE);
    check_val("single_ferr", frame_err, 1'b0);
    check_val("single_busy", busy, 1'b0);
    drive_bit(1'b0);
    check_val("single_valid_drop", packet_valid, 1'b0);

    // bad stop bit, then a good frame
    send_frame(P_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("badstop_ferr", frame_err, 1'b1);
    check_val("badstop_valid", packet_valid, 1'b0);
    drive_bit(1'b0);
    check_val("badstop_ferr_pulse", frame_err, 1'b0);
    check_val("badstop_busy", busy, 1'b0);
    send_frame(P_GOOD2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("after_bad_valid", packet_valid, 1'b1);
    drive_bit(1'b0);

    // overrun: back-to-back A, B with no consumer
    packet_ready = 1'b0;
    send_frame(P_A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("ovr_a_valid", packet_valid, 1'b1);
    check_val("ovr_a_flag", overrun, 1'b0);
    send_frame(P_B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("ovr_flag", overrun, 1'b1);
    check_val("ovr_data_held", packet_data, P_A);
    check_val("ovr_valid_held", packet_valid, 1'b1);
    clear_errors = 1'b1;
    drive_bit(1'b0);
    clear_errors = 1'b0;
    check_val("ovr_cleared", overrun, 1'b0);
    check_val("ovr_data_after_clr", packet_data, P_A);
    packet_ready = 1'b1;
    drive_bit(1'b0);
    check_val("ovr_accepted", packet_valid, 1'b0);

    // accept and reload on the same edge
    packet_ready = 1'b0;
    send_frame(P_C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("reload_c_data", packet_data, P_C);
    send_frame(P_D, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("reload_valid", packet_valid, 1'b1);
    check_val("reload_data", packet_data, P_D);
    check_val("reload_ovr", overrun, 1'b0);
    drive_bit(1'b0);
    check_val("reload_done", packet_valid, 1'b0);

    // start bits ignored while disabled in IDLE
    rx_enable = 1'b0;
    repeat (4) drive_bit(1'b1);
    check_val("rxdis_busy", busy, 1'b0);
    rx_enable = 1'b1;
    gpio_packet = 1'b0;
    drive_bit(1'b0);
    check_val("rxdis_valid", packet_valid, 1'b0);

    // disabling mid-frame lets the current frame finish
    send_frame(P_E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_val("rxoff_mid_valid", packet_valid, 1'b1);
    drive_bit(1'b0);

`ifdef PARITY_CHECK_EN
    send_frame(P_B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("par_ferr", frame_err, 1'b1);
    check_val("par_valid", packet_valid, 1'b0);
    drive_bit(1'b0);
`endif

    // reset mid-frame with a held packet pending
    packet_ready = 1'b0;
    send_frame(P_B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1);
    for (int i = 0; i < 20; i++) drive_bit(i[0]);
    reset_n = 1'b0;
    gpio_packet = 1'b0;
    repeat (3) drive_bit(1'b0);
    check_val("midrst_valid", packet_valid, 1'b0);
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_ovr", overrun, 1'b0);
    check_val("midrst_ferr", frame_err, 1'b0);
    check_val("midrst_data", packet_data, '0);
    reset_n = 1'b1;
    drive_bit(1'b0);
    check_val("postrst_ferr", frame_err, 1'b0);
    packet_ready = 1'b1;
    send_frame(P_RST, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("postrst_data", packet_data, P_RST);
    repeat (3) drive_bit(1'b0);

    check_val("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
